// File: rtl/dropdown_pkg.sv
// Shared types and widths for the drop-down sprite sequencer.
// Optional gravity build is selected by DROPDOWN_ACCEL_EN in dropdown_ctrl.
package dropdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DROP   = 2'd1,
        LANDED = 2'd2
    } state_t;

    localparam int DIV_W = 6;
    localparam int CNT_W = 6;

endpackage

// File: rtl/dropdown_frame_div_counter.sv
// Frame-tick divider: 6-bit up-counter, synchronous clear dominates enable.
module frame_div_counter
    import dropdown_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    output logic [DIV_W-1:0] Q
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Q <= '0;
        else if (Clr)
            Q <= '0;
        else if (En)
            Q <= Q + 1'b1;
    end

endmodule

// File: rtl/dropdown_ctrl.sv
// Drop-down sprite sequencer: one falling sprite per Start, stepped every FRAME_DIV frame ticks.
// Define DROPDOWN_ACCEL_EN to add a velocity register that grows by one per step up to MAX_VEL.
//
//   state  | meaning
//   IDLE   | waiting for Start, Pos_Y parked at START_Y
//   DROP   | sprite falling, Pos_Y advances on divided frame ticks
//   LANDED | sprite at FLOOR_Y, waiting for Ack (or Abort)
module dropdown_ctrl
    import dropdown_pkg::*;
#(
    parameter int POS_W     = 10,
    parameter int FRAME_DIV = 4,
    parameter int START_Y   = 0,
    parameter int FLOOR_Y   = 440,
    parameter int STEP      = 4,
    parameter int MAX_VEL   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Frame_Tick,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Ack,
    output logic             Busy,
    output logic             Landed,
    output logic [POS_W-1:0] Pos_Y,
    output logic [CNT_W-1:0] Drop_Cnt
);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START_Y);
    localparam logic [POS_W-1:0] FLOOR_POS = POS_W'(FLOOR_Y);
    localparam logic [POS_W-1:0] STEP_VEL  = POS_W'(STEP);

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic             step_due;
    logic             div_clr;
    logic [POS_W-1:0] vel;
    logic [POS_W:0]   pos_sum;
    logic [POS_W-1:0] pos_next;

`ifdef DROPDOWN_ACCEL_EN
    localparam logic [POS_W-1:0] MAX_V = POS_W'(MAX_VEL);
    logic [POS_W-1:0] vel_next;
    assign vel_next = (vel >= MAX_V) ? MAX_V : vel + 1'b1;
`else
    // Legal configurations have STEP <= MAX_VEL, so this is simply STEP.
    assign vel = POS_W'((STEP <= MAX_VEL) ? STEP : MAX_VEL);
`endif

    assign step_due = (state == DROP) && Frame_Tick && (div_q == DIV_LAST);
    // Divider only runs in DROP; any exit or step returns it to 0.
    assign div_clr  = (state != DROP) || Abort || step_due;

    assign pos_sum  = {1'b0, Pos_Y} + {1'b0, vel};
    assign pos_next = (pos_sum >= {1'b0, FLOOR_POS}) ? FLOOR_POS : pos_sum[POS_W-1:0];

    frame_div_counter u_frame_div (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (div_clr),
        .En    (Frame_Tick),
        .Q     (div_q)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Landed   <= 1'b0;
            Pos_Y    <= START_POS;
            Drop_Cnt <= '0;
`ifdef DROPDOWN_ACCEL_EN
            vel      <= STEP_VEL;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start && !Abort) begin
                        state <= DROP;
                        Busy  <= 1'b1;
                        Pos_Y <= START_POS;
`ifdef DROPDOWN_ACCEL_EN
                        vel   <= STEP_VEL;
`endif
                    end
                end
                DROP: begin
                    if (Abort) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Pos_Y <= START_POS;
                    end else if (step_due) begin
                        Pos_Y <= pos_next;
`ifdef DROPDOWN_ACCEL_EN
                        vel   <= vel_next;
`endif
                        if (pos_next == FLOOR_POS) begin
                            state  <= LANDED;
                            Landed <= 1'b1;
                        end
                    end
                end
                LANDED: begin
                    if (Abort || Ack) begin
                        state  <= IDLE;
                        Busy   <= 1'b0;
                        Landed <= 1'b0;
                        Pos_Y  <= START_POS;
                        if (!Abort)
                            Drop_Cnt <= Drop_Cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    Landed <= 1'b0;
                    Pos_Y  <= START_POS;
                end
            endcase
        end
    end

`ifndef DROPDOWN_ACCEL_EN
    logic unused_step;
    assign unused_step = ^STEP_VEL;
`endif

endmodule
